// File: rtl/aes_pkg.sv
// Shared AES constants, the sequencer state type and the LANES legality check
// used by the low-area decrypt datapath.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic bit lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
  endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// Valid/ready stream bundle carrying one 128-bit AES state in and one out.
interface inv_sub_bytes_seq_if;

  logic                          in_valid;
  logic                          in_ready;
  logic [aes_pkg::AES_STATE_W-1:0] din;
  logic                          out_valid;
  logic                          out_ready;
  logic [aes_pkg::AES_STATE_W-1:0] dout;

  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, dout
  );

  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, dout
  );

endinterface

// File: rtl/inv_sbox.sv
// AES inverse S-box with one registered cycle of latency: inverse affine map
// followed by the GF(2^8) multiplicative inverse (computed as a^254).
module inv_sbox (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // a^254 = product of a^(2^i) for i = 1..7; zero maps to zero as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) dout <= '0;
    else     dout <= gf_inv(inv_affine(din));
  end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Time-multiplexed InvSubBytes: LANES shared inv_sbox instances process the
// 16 state bytes over PASSES beats. Optional block counter: INV_SUB_SEQ_PERF_EN.
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                clk,
  input  logic                rst,
  inv_sub_bytes_seq_if.slave  bus,
  output logic                busy
`ifdef INV_SUB_SEQ_PERF_EN
  ,
  output logic [31:0]         blk_count
`endif
);

  localparam int PASSES = AES_BYTES / LANES;
  localparam int BEAT_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PASSES - 1);

  if (!lanes_legal(LANES)) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  // Slice k, lane j is state byte k*LANES+j.
  typedef logic [PASSES-1:0][LANES-1:0][7:0] slices_t;

  state_e               state_q, state_d;
  slices_t              din_q;
  slices_t              dout_q;
  logic [BEAT_W-1:0]    beat_q;
  logic                 tag_v_q;
  logic [BEAT_W-1:0]    tag_k_q;
  logic [LANES-1:0][7:0] sbox_in;
  logic [LANES-1:0][7:0] sbox_out;
  logic                 in_ready;
  logic                 out_valid;
  logic                 in_fire;
  logic                 out_fire;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (beat_q == LAST_BEAT) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy    = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_fire       = in_ready && bus.in_valid;
  assign out_fire      = out_valid && bus.out_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.dout      = dout_q;

  assign sbox_in = din_q[beat_q];

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    inv_sbox u_sbox (
      .clk  (clk),
      .rst  (rst),
      .din  (sbox_in[j]),
      .dout (sbox_out[j])
    );
  end

  // The capture tag follows the issued beat by one cycle, matching the S-box
  // register, so it names the slice currently on sbox_out.
  // NOTE: dout_q is reset because a reset must discard any partial result
  // and present zero on dout.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q   <= '0;
      beat_q  <= '0;
      tag_v_q <= 1'b0;
      tag_k_q <= '0;
      dout_q  <= '0;
    end else begin
      if (in_fire) begin
        din_q  <= bus.din;
        beat_q <= '0;
      end else if (state_q == ST_RUN && beat_q != LAST_BEAT) begin
        beat_q <= beat_q + BEAT_W'(1);
      end
      tag_v_q <= (state_q == ST_RUN);
      tag_k_q <= beat_q;
      if (tag_v_q) dout_q[tag_k_q] <= sbox_out;
    end
  end

`ifdef INV_SUB_SEQ_PERF_EN
  logic [31:0] blk_count_q;

  always_ff @(posedge clk) begin
    if (rst)           blk_count_q <= '0;
    else if (out_fire) blk_count_q <= blk_count_q + 32'd1;
  end

  assign blk_count = blk_count_q;
`else
  logic unused_out_fire;
  assign unused_out_fire = out_fire;
`endif

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench: three engines (LANES 1, 4, 16) against an inverse
// S-box table derived from the FIPS-197 forward S-box construction.
module tb_inv_sub_bytes_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic         in_valid_a  [3];
  logic [127:0] din_a       [3];
  logic         out_ready_a [3];
  wire          in_ready_a  [3];
  wire          out_valid_a [3];
  wire  [127:0] dout_a      [3];
  wire          busy_a      [3];
`ifdef INV_SUB_SEQ_PERF_EN
  wire  [31:0]  cnt_a       [3];
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    inv_sub_bytes_seq_if bus ();
    assign bus.in_valid   = in_valid_a[g];
    assign bus.din        = din_a[g];
    assign bus.out_ready  = out_ready_a[g];
    assign in_ready_a[g]  = bus.in_ready;
    assign out_valid_a[g] = bus.out_valid;
    assign dout_a[g]      = bus.dout;
    inv_sub_bytes_seq #(.LANES(L)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy      (busy_a[g])
`ifdef INV_SUB_SEQ_PERF_EN
      ,
      .blk_count (cnt_a[g])
`endif
    );
  end

  // ---------------- reference model ----------------
  logic [7:0]   inv_tbl [256];
  logic [127:0] stim_q [$];
  logic [127:0] got_q  [$];

  function automatic int gmul(input int a, input int b);
    int p = 0;
    for (int i = 0; i < 8; i++) begin
      if ((b >> i) & 1) p = p ^ a;
      a = a << 1;
      if (a & 'h100) a = a ^ 'h11b;
    end
    return p;
  endfunction

  function automatic int rotl8(input int x, input int n);
    return ((x << n) | (x >> (8 - n))) & 'hff;
  endfunction

  task automatic build_table();
    for (int b = 0; b < 256; b++) begin
      int inv = 0;
      int s;
      for (int y = 1; y < 256 && b != 0; y++)
        if (gmul(b, y) == 1) inv = y;
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 'h63;
      inv_tbl[s] = 8'(b);
    end
  endtask

  function automatic logic [127:0] exp_block(input logic [127:0] d);
    logic [127:0] e;
    for (int i = 0; i < 16; i++) e[8*i +: 8] = inv_tbl[d[8*i +: 8]];
    return e;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int lanes_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 16);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Streams every block of stim_q into engine d with in_valid held high.
  // Each DONE is backpressured for 'stall' cycles before out_ready rises.
  task automatic run_stream(input int d, input int stall, input string tag);
    int passes    = 16 / lanes_of(d);
    int n         = stim_q.size();
    int c         = 0;
    int nxt       = 1;
    int done_n    = 0;
    int stall_cnt = 0;
    int acc_t [$];
    int hs_t  [$];
    logic [127:0] exp_q [$];
    logic acc_prev = 1'b0;
    logic ov_prev  = 1'b0;
    got_q.delete();
    @(negedge clk);
    in_valid_a[d]  = 1'b1;
    din_a[d]       = stim_q[0];
    out_ready_a[d] = 1'b1;
    while (done_n < n && c < 4000) begin
      if (acc_prev) begin
        if (nxt < n) begin
          din_a[d] = stim_q[nxt];
          nxt++;
        end else begin
          in_valid_a[d] = 1'b0;
          din_a[d]      = rand128();
        end
      end
      out_ready_a[d] = 1'b1;
      if (out_valid_a[d] && stall_cnt < stall) begin
        out_ready_a[d] = 1'b0;
        stall_cnt++;
      end
      acc_prev = in_valid_a[d] && in_ready_a[d];
      if (acc_prev) begin
        acc_t.push_back(c);
        exp_q.push_back(exp_block(din_a[d]));
        if (acc_t.size() > 1) begin
          check({tag, " accept_after_handshake"}, 128'(c),
                (hs_t.size() > 0) ? 128'(hs_t[$] + 1) : '1);
          if (stall == 0)
            check({tag, " b2b_gap"}, 128'(c - acc_t[acc_t.size()-2]), 128'(passes + 3));
        end
      end
      if (out_valid_a[d]) begin
        if (!ov_prev)
          check({tag, " latency"}, 128'(c - ((acc_t.size() > done_n) ? acc_t[done_n] : 0)),
                128'(passes + 2));
        if (!out_ready_a[d]) begin
          check({tag, " stall_dout"}, dout_a[d], exp_q[0]);
          check({tag, " stall_in_ready"}, 128'(in_ready_a[d]), 128'(0));
        end else begin
          check({tag, " dout"}, dout_a[d], exp_q[0]);
          got_q.push_back(dout_a[d]);
          void'(exp_q.pop_front());
          hs_t.push_back(c);
          done_n++;
          stall_cnt = 0;
        end
      end
      ov_prev = out_valid_a[d];
      @(negedge clk);
      c++;
    end
    check({tag, " blocks_completed"}, 128'(done_n), 128'(n));
    in_valid_a[d]  = 1'b0;
    out_ready_a[d] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]   pat_in  [5];
    logic [7:0]   pat_out [5];
    logic [127:0] fips_in, fips_out, blk;
    int           perm [256];

    pat_in  = '{8'h00, 8'h01, 8'h63, 8'h7c, 8'hff};
    pat_out = '{8'h52, 8'h09, 8'h00, 8'h01, 8'h7d};
    for (int d = 0; d < 3; d++) begin
      in_valid_a[d]  = 1'b0;
      din_a[d]       = '0;
      out_ready_a[d] = 1'b1;
    end
    build_table();

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_in_ready_%0d", d), 128'(in_ready_a[d]), 128'(1));
      check($sformatf("reset_out_valid_%0d", d), 128'(out_valid_a[d]), 128'(0));
      check($sformatf("reset_busy_%0d", d), 128'(busy_a[d]), 128'(0));
      check($sformatf("reset_dout_%0d", d), dout_a[d], 128'(0));
    end
    rst = 1'b0;

    // FIPS-197 directed bytes
    for (int i = 0; i < 16; i++) begin
      fips_in[8*i +: 8]  = pat_in[i % 5];
      fips_out[8*i +: 8] = pat_out[i % 5];
    end
    stim_q.delete();
    stim_q.push_back(fips_in);
    run_stream(1, 0, "fips");
    check("fips_const", (got_q.size() > 0) ? got_q[0] : '0, fips_out);

    // Exhaustive byte coverage, shuffled, on each lane count
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 256; i++) perm[i] = i;
      for (int i = 255; i > 0; i--) begin
        int j = $urandom_range(i, 0);
        int t = perm[i];
        perm[i] = perm[j];
        perm[j] = t;
      end
      stim_q.delete();
      for (int b = 0; b < 16; b++) begin
        for (int i = 0; i < 16; i++) blk[8*i +: 8] = 8'(perm[16*b + i]);
        stim_q.push_back(blk);
      end
      run_stream(d, 0, $sformatf("exh_lanes%0d", lanes_of(d)));
    end

    // Back-to-back random blocks
    stim_q.delete();
    repeat (3) stim_q.push_back(rand128());
    run_stream(1, 0, "b2b");

    // Backpressure: 10 stalled DONE cycles with a second block waiting
    stim_q.delete();
    repeat (2) stim_q.push_back(rand128());
    run_stream(1, 10, "bp");

    // Reset during RUN beat 2
    @(negedge clk);
    in_valid_a[1] = 1'b1;
    din_a[1]      = rand128();
    @(negedge clk);
    in_valid_a[1] = 1'b0;
    din_a[1]      = rand128();
    repeat (2) @(negedge clk);
    check("midrst_busy_before", 128'(busy_a[1]), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", 128'(in_ready_a[1]), 128'(1));
    check("midrst_out_valid", 128'(out_valid_a[1]), 128'(0));
    check("midrst_busy", 128'(busy_a[1]), 128'(0));
    check("midrst_dout", dout_a[1], 128'(0));
    stim_q.delete();
    stim_q.push_back(rand128());
    run_stream(1, 0, "after_rst");

`ifdef INV_SUB_SEQ_PERF_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    stim_q.delete();
    repeat (5) stim_q.push_back(rand128());
    run_stream(1, 0, "perf");
    check("perf_count5", 128'(cnt_a[1]), 128'(5));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("perf_cleared", 128'(cnt_a[1]), 128'(0));
    force g_dut[1].u_dut.blk_count_q = 32'hffff_ffff;
    @(negedge clk);
    release g_dut[1].u_dut.blk_count_q;
    check("perf_preload", 128'(cnt_a[1]), 128'(32'hffff_ffff));
    stim_q.delete();
    stim_q.push_back(rand128());
    run_stream(1, 0, "perf_wrap");
    check("perf_wrap", 128'(cnt_a[1]), 128'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
